// File: rtl/sha_strip_gate.sv
// sha_strip_gate: store-and-forward gate behind the SHA verifier.
// Each message is buffered (data beats plus a trailing digest beat). When the
// per-message verdict arrives, a passing message is replayed without its
// digest beat, with tlast moved to the new final beat. A failing message, or
// one longer than DEPTH beats, is dropped. Pass, fail and overflow counts are
// kept for host readout.
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   inp_*                  AXI-Stream input (data, keep, id, last, valid/ready)
//   verdict*               per-message verdict (1 = digest matched)
//   out_*                  AXI-Stream output, registered
//   pass/fail/ovf_count    wrapping 32-bit message counters
module sha_strip_gate #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned ID_W   = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] inp_data,
  input  logic [KEEP_W-1:0] inp_keep,
  input  logic [ID_W-1:0]   inp_id,
  input  logic              inp_last,
  input  logic              inp_valid,
  output logic              inp_ready,
  input  logic              verdict,
  input  logic              verdict_valid,
  output logic              verdict_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic [ID_W-1:0]   out_id,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       pass_count,
  output logic [31:0]       fail_count,
  output logic [31:0]       ovf_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATA_W + KEEP_W + ID_W;

  typedef enum logic [1:0] {
    FILL,
    OVERFLOW,
    WAIT_VERDICT,
    DRAIN
  } state_t;

  logic [EW-1:0] mem [DEPTH];

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] n;
  logic          ovf_flag;

  logic          in_fire_c;
  logic          vd_fire_c;
  logic          out_fire_c;
  logic          wr_en_c;
  logic          start_drain_c;
  logic          rd_en_c;
  logic [AW-1:0] rd_next_c;
  logic [AW-1:0] rd_addr_c;

  assign in_fire_c  = inp_valid & inp_ready;
  assign vd_fire_c  = verdict_valid & verdict_ready;
  assign out_fire_c = out_valid & out_ready;
  assign wr_en_c    = in_fire_c & (state == FILL);

  // Passing verdict with at least one data beat ahead of the digest.
  assign start_drain_c = vd_fire_c & verdict & ~ovf_flag & (n >= CW'(2));

  // Read ahead: the RAM read register is the output register, so a new read
  // is issued only when the output slot is being loaded or advanced.
  assign rd_next_c = rd_ptr + AW'(1);
  assign rd_en_c   = start_drain_c | (out_fire_c & ~out_last);
  assign rd_addr_c = start_drain_c ? '0 : rd_next_c;

  // Buffer write port; contents need no reset since pointers are cleared.
  always_ff @(posedge clock) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= {inp_data, inp_keep, inp_id};
    end
  end

  // Control FSM, read port and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= FILL;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      n             <= '0;
      ovf_flag      <= 1'b0;
      inp_ready     <= 1'b0;
      verdict_ready <= 1'b0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_data      <= '0;
      out_keep      <= '0;
      out_id        <= '0;
      pass_count    <= '0;
      fail_count    <= '0;
      ovf_count     <= '0;
    end else begin
      if (rd_en_c) begin
        {out_data, out_keep, out_id} <= mem[rd_addr_c];
      end

      case (state)
        FILL: begin
          inp_ready <= 1'b1;
          if (in_fire_c) begin
            wr_ptr <= wr_ptr + AW'(1);
            n      <= n + CW'(1);
            if (inp_last) begin
              state         <= WAIT_VERDICT;
              inp_ready     <= 1'b0;
              verdict_ready <= 1'b1;
            end else if (n == CW'(DEPTH - 1)) begin
              // Buffer full and no tlast yet: message cannot fit.
              state <= OVERFLOW;
            end
          end
        end

        OVERFLOW: begin
          if (in_fire_c && inp_last) begin
            state         <= WAIT_VERDICT;
            ovf_flag      <= 1'b1;
            inp_ready     <= 1'b0;
            verdict_ready <= 1'b1;
          end
        end

        WAIT_VERDICT: begin
          if (vd_fire_c) begin
            verdict_ready <= 1'b0;
            if (ovf_flag) begin
              ovf_count <= ovf_count + 32'd1;
            end else if (!verdict) begin
              fail_count <= fail_count + 32'd1;
            end else begin
              pass_count <= pass_count + 32'd1;
            end

            if (start_drain_c) begin
              state     <= DRAIN;
              rd_ptr    <= '0;
              out_valid <= 1'b1;
              out_last  <= (n == CW'(2));
            end else begin
              state     <= FILL;
              inp_ready <= 1'b1;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
              n         <= '0;
              ovf_flag  <= 1'b0;
            end
          end
        end

        DRAIN: begin
          if (out_fire_c) begin
            if (out_last) begin
              state     <= FILL;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              inp_ready <= 1'b1;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
              n         <= '0;
            end else begin
              rd_ptr   <= rd_next_c;
              // Last forwarded beat is index n-2; index n-1 is the digest.
              out_last <= (CW'(rd_next_c) == (n - CW'(2)));
            end
          end
        end
      endcase
    end
  end

endmodule
